// File: rtl/vga_text_fetch.sv
// Text-mode character fetch and pixel shifter: fetches one cell ahead from text RAM and the font ROM.
// Optional cursor (blinking fg/bg swap) is enabled with `define CURSOR_EN.
module vga_text_fetch (
  input  logic        pclk,
  input  logic        rst,
  input  logic [9:0]  col,
  input  logic [9:0]  row,
  input  logic        blank_n,
  input  logic        shload_n,
  output logic        vram_req,
  output logic [11:0] vram_addr,
  input  logic        vram_ack,
  input  logic [15:0] vram_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
`ifdef CURSOR_EN
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
`endif
  output logic [3:0]  pix,
  output logic        underrun
);

  typedef enum logic [2:0] {IDLE, REQ, FONT, FCAP, READY} state_t;

  state_t      state_q, state_d;
  logic        vram_req_q, vram_req_d;
  logic [11:0] vram_addr_q, vram_addr_d;
  logic [11:0] font_addr_q, font_addr_d;
  logic [3:0]  lnib_q, lnib_d;
  logic [3:0]  fg_q, fg_d, bg_q, bg_d;
  logic [7:0]  hold_pat_q, hold_pat_d;
  logic [3:0]  hold_fg_q, hold_fg_d, hold_bg_q, hold_bg_d;
  logic        hold_valid_q, hold_valid_d;
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  sh_fg_q, sh_fg_d, sh_bg_q, sh_bg_d;
  logic [3:0]  pix_q, pix_d;
  logic        underrun_q, underrun_d;
  logic        armed_q, armed_d;
  logic        swap;

  logic        trig;
  logic [6:0]  cell_t;
  logic [9:0]  row_inc, line_t;
  logic        skip_t;
  logic [11:0] addr_t;

  assign trig    = ~shload_n;
  assign cell_t  = (col[9:3] == 7'd99) ? 7'd0 : col[9:3] + 7'd1;
  assign row_inc = (row == 10'd524) ? 10'd0 : row + 10'd1;
  assign line_t  = (cell_t == 7'd0) ? row_inc : row;
  assign skip_t  = (cell_t >= 7'd80) || (line_t >= 10'd480);
  assign addr_t  = 12'(line_t[8:4]) * 12'd80 + 12'(cell_t);

`ifdef CURSOR_EN
  logic [5:0] frame_q, frame_d;
  logic       cur_hit_q, cur_hit_d;
  assign frame_d = frame_q + {5'd0, (row == 10'd0) && (col == 10'd0)};
  assign swap    = cur_hit_q & frame_q[5];
  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_q   <= '0;
      cur_hit_q <= 1'b0;
    end else begin
      frame_q   <= frame_d;
      cur_hit_q <= cur_hit_d;
    end
  end
`else
  logic unused_col;
  assign unused_col = &{1'b0, col[2:0]};
  assign swap       = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    vram_req_d   = vram_req_q;
    vram_addr_d  = vram_addr_q;
    font_addr_d  = font_addr_q;
    lnib_d       = lnib_q;
    fg_d         = fg_q;
    bg_d         = bg_q;
    hold_pat_d   = hold_pat_q;
    hold_fg_d    = hold_fg_q;
    hold_bg_d    = hold_bg_q;
    hold_valid_d = hold_valid_q;
    underrun_d   = underrun_q;
    armed_d      = armed_q;
    sh_d         = {sh_q[6:0], 1'b0};
    sh_fg_d      = sh_fg_q;
    sh_bg_d      = sh_bg_q;
    pix_d        = blank_n ? 4'd0 : (sh_q[7] ? sh_fg_q : sh_bg_q);
`ifdef CURSOR_EN
    cur_hit_d    = cur_hit_q;
`endif

    case (state_q)
      REQ: if (vram_ack) begin
        state_d     = FONT;
        vram_req_d  = 1'b0;
        font_addr_d = {vram_data[7:0], lnib_q};
        fg_d        = vram_data[11:8];
        bg_d        = vram_data[15:12];
      end
      FONT: state_d = FCAP;
      FCAP: begin
        hold_pat_d   = font_data;
        hold_fg_d    = swap ? bg_q : fg_q;
        hold_bg_d    = swap ? fg_q : bg_q;
        hold_valid_d = 1'b1;
        state_d      = READY;
      end
      default: ;
    endcase

    // A trigger overrides whatever fetch is in flight and retargets the FSM.
    if (trig) begin
      if (!hold_valid_q && armed_q) begin
        underrun_d = 1'b1;
        sh_d       = '0;
        sh_fg_d    = '0;
        sh_bg_d    = '0;
      end else begin
        sh_d       = hold_pat_q;
        sh_fg_d    = hold_fg_q;
        sh_bg_d    = hold_bg_q;
      end
      hold_valid_d = 1'b0;
      armed_d      = 1'b1;
      if (skip_t) begin
        hold_pat_d   = '0;
        hold_fg_d    = '0;
        hold_bg_d    = '0;
        hold_valid_d = 1'b1;
        vram_req_d   = 1'b0;
        state_d      = READY;
      end else begin
        vram_req_d   = 1'b1;
        vram_addr_d  = addr_t;
        lnib_d       = line_t[3:0];
        state_d      = REQ;
`ifdef CURSOR_EN
        cur_hit_d    = (cell_t == cursor_col) && (line_t[8:4] == cursor_row);
`endif
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= IDLE;
      vram_req_q   <= 1'b0;
      vram_addr_q  <= '0;
      font_addr_q  <= '0;
      lnib_q       <= '0;
      fg_q         <= '0;
      bg_q         <= '0;
      hold_pat_q   <= '0;
      hold_fg_q    <= '0;
      hold_bg_q    <= '0;
      hold_valid_q <= 1'b0;
      sh_q         <= '0;
      sh_fg_q      <= '0;
      sh_bg_q      <= '0;
      pix_q        <= '0;
      underrun_q   <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      vram_req_q   <= vram_req_d;
      vram_addr_q  <= vram_addr_d;
      font_addr_q  <= font_addr_d;
      lnib_q       <= lnib_d;
      fg_q         <= fg_d;
      bg_q         <= bg_d;
      hold_pat_q   <= hold_pat_d;
      hold_fg_q    <= hold_fg_d;
      hold_bg_q    <= hold_bg_d;
      hold_valid_q <= hold_valid_d;
      sh_q         <= sh_d;
      sh_fg_q      <= sh_fg_d;
      sh_bg_q      <= sh_bg_d;
      pix_q        <= pix_d;
      underrun_q   <= underrun_d;
      armed_q      <= armed_d;
    end
  end

  // A request still pending at a trigger is abandoned, so it is masked in that cycle.
  assign vram_req  = vram_req_q & shload_n;
  assign vram_addr = vram_addr_q;
  assign font_addr = font_addr_q;
  assign pix       = pix_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_vga_text_fetch.sv
// Scoreboard bench for vga_text_fetch: directed timing-generator sweeps, queued expectations, decoupled monitor.
module tb_vga_text_fetch;
  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  col = '0, row = '0;
  logic        blank_n = 1'b0, shload_n = 1'b1;
  logic        vram_req, vram_ack = 1'b0;
  logic [11:0] vram_addr, font_addr;
  logic [15:0] vram_data = '0;
  logic [7:0]  font_data = '0;
  logic [3:0]  pix;
  logic        underrun;
`ifdef CURSOR_EN
  logic [6:0]  cursor_col = 7'd2;
  logic [4:0]  cursor_row = 5'd0;
  localparam logic [3:0] FGA = 4'h3, BGA = 4'hC;
`else
  localparam logic [3:0] FGA = 4'hC, BGA = 4'h3;
`endif

  vga_text_fetch dut (
    .pclk(pclk), .rst(rst), .col(col), .row(row), .blank_n(blank_n), .shload_n(shload_n),
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack), .vram_data(vram_data),
    .font_addr(font_addr), .font_data(font_data),
`ifdef CURSOR_EN
    .cursor_col(cursor_col), .cursor_row(cursor_row),
`endif
    .pix(pix), .underrun(underrun)
  );

  always #5 pclk = ~pclk;

  int nvec = 0, nerr = 0, cyc = 0;
  always @(posedge pclk) cyc++;

  typedef struct { int cyc; logic [3:0] val; } pix_exp_t;
  logic [11:0] exp_addr_q[$], exp_font_q[$];
  int          rsp_dly_q[$];
  logic [15:0] rsp_dat_q[$];
  pix_exp_t    exp_pix_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Font ROM: a few hand-placed glyph rows, otherwise char ^ {line,line}.
  function automatic logic [7:0] rom(input logic [11:0] a);
    rom = (a == 12'h410) ? 8'hAA : (a[11:4] ^ {a[3:0], a[3:0]});
  endfunction
  always @(posedge pclk) font_data <= rom(font_addr);

  // Text-RAM responder: each new request takes the next delay/data from the queues.
  int n = 0, cur_dly = 1;
  always @(posedge pclk) begin
    #2;
    if (rst || !vram_req) begin
      n = 0;
      vram_ack = 1'b0;
    end else begin
      if (n == 0) begin
        cur_dly   = (rsp_dly_q.size() > 0) ? rsp_dly_q.pop_front() : 1;
        vram_data = (rsp_dat_q.size() > 0) ? rsp_dat_q.pop_front() : 16'h0000;
      end
      n++;
      vram_ack = (n == cur_dly);
    end
  end

  logic prev_req = 1'b0, hs = 1'b0;
  always @(posedge pclk) hs <= vram_req & vram_ack & ~rst;

  always @(negedge pclk) begin : mon
    pix_exp_t e;
    if (vram_req && !prev_req) begin
      if (exp_addr_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_req: got addr %0d expected no request (cycle %0d)", vram_addr, cyc);
      end else chk("vram_addr", {20'd0, vram_addr}, {20'd0, exp_addr_q.pop_front()});
    end
    prev_req = vram_req;
    if (hs) begin
      if (exp_font_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_font: got %0h expected no font fetch", font_addr);
      end else chk("font_addr", {20'd0, font_addr}, {20'd0, exp_font_q.pop_front()});
    end
    while (exp_pix_q.size() > 0 && exp_pix_q[0].cyc <= cyc) begin
      e = exp_pix_q.pop_front();
      chk("pix", {28'd0, pix}, {28'd0, e.val});
    end
  end

  task automatic tick(input int c, input int r, input bit pc, input logic [3:0] pe);
    col      = c[9:0];
    row      = r[9:0];
    shload_n = !(c[2:0] == 3'd7);
    blank_n  = (c >= 640) || (r >= 480);
    if (pc) exp_pix_q.push_back('{cyc + 1, pe});
    @(posedge pclk); #1;
  endtask

  // Sweep cols c0..c1 on row r; pixels after cols pc0..pc0+7 expected from pat/fg/bg.
  task automatic run(input int r, input int c0, input int c1, input int pc0,
                     input logic [7:0] pat, input logic [3:0] fg, input logic [3:0] bg);
    for (int c = c0; c <= c1; c++) begin
      int k;
      bit pc;
      logic [3:0] ev;
      k  = c - pc0;
      pc = (k >= 0) && (k < 8);
      ev = 4'd0;
      if (pc) ev = pat[7-k] ? fg : bg;
      tick(c, r, pc, ev);
    end
  endtask

  task automatic expect_req(input logic [11:0] a, input logic [15:0] d, input int dly, input int fa);
    exp_addr_q.push_back(a);
    rsp_dat_q.push_back(d);
    rsp_dly_q.push_back(dly);
    if (fa >= 0) exp_font_q.push_back(fa[11:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge pclk); #1;
    rst = 1'b1;
    repeat (3) tick(0, 0, 1'b0, 4'd0);
    chk("rst_pix", {28'd0, pix}, 32'd0);
    chk("rst_req", {31'd0, vram_req}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_vram_addr", {20'd0, vram_addr}, 32'd0);
    chk("rst_font_addr", {20'd0, font_addr}, 32'd0);
    rst = 1'b0;
    repeat (32) tick(0, 0, 1'b0, 4'd0);

    // Row 0: cells 2..5, first fetch carries 0x3C41 / glyph 0xAA.
    expect_req(12'd2, 16'h3C41, 1, 'h410);
    expect_req(12'd3, 16'h12F0, 1, 'hF00);
    expect_req(12'd4, 16'h7800, 1, 'h000);
    expect_req(12'd5, 16'h0000, 1, 'h000);
    run(0, 8, 23, 16, 8'h00, 4'h0, 4'h0);
    run(0, 24, 31, 24, 8'hAA, FGA, BGA);
    run(0, 32, 39, 32, 8'hF0, 4'h2, 4'h1);
    run(0, 40, 45, 40, 8'h00, 4'h8, 4'h7);
    chk("underrun_A", {31'd0, underrun}, 32'd0);

    // End of row 15: target wraps to cell 0 of line 16.
    expect_req(12'd80, 16'h1E55, 1, 'h550);
    expect_req(12'd81, 16'h0000, 1, 'h000);
    expect_req(12'd82, 16'h0000, 1, 'h000);
    run(15, 792, 799, 792, 8'h00, 4'h0, 4'h0);
    run(16, 0, 7, -100, 8'h00, 4'h0, 4'h0);
    run(16, 8, 15, 8, 8'h55, 4'hE, 4'h1);
    run(16, 16, 19, 16, 8'h00, 4'h0, 4'h0);

    // Cell 79 fetched, cells 80/81 skipped.
    expect_req(12'd79, 16'h0000, 1, 'h000);
    run(0, 624, 650, 640, 8'h00, 4'h0, 4'h0);

    // Vertical blanking rows: no requests.
    run(480, 0, 24, 8, 8'h00, 4'h0, 4'h0);
    chk("blank_req", {31'd0, vram_req}, 32'd0);

    // Last row wraps to line 0.
    expect_req(12'd0, 16'h0000, 1, 'h000);
    expect_req(12'd1, 16'h1E55, 1, 'h550);
    run(524, 792, 799, -100, 8'h00, 4'h0, 4'h0);
    run(0, 0, 11, -100, 8'h00, 4'h0, 4'h0);
    chk("underrun_skip", {31'd0, underrun}, 32'd0);

    // Late ack (6 cycles) causes underrun; following cell recovers.
    expect_req(12'd81, 16'h9F77, 6, 'h770);
    expect_req(12'd82, 16'h2DAA, 1, 'hAA0);
    expect_req(12'd83, 16'h0000, 1, 'h000);
    expect_req(12'd84, 16'h0000, 1, 'h000);
    run(16, 0, 15, 8, 8'h55, 4'hE, 4'h1);
    chk("underrun_set", {31'd0, underrun}, 32'd1);
    run(16, 16, 23, 16, 8'h00, 4'h0, 4'h0);
    run(16, 24, 31, 24, 8'hAA, 4'hD, 4'h2);
    chk("underrun_sticky", {31'd0, underrun}, 32'd1);

    // Reset during an outstanding request, then a clean first trigger.
    expect_req(12'd85, 16'h0000, 3, -1);
    run(16, 32, 39, 32, 8'h00, 4'h0, 4'h0);
    rst = 1'b1;
    tick(40, 16, 1'b0, 4'd0);
    tick(41, 16, 1'b0, 4'd0);
    rst = 1'b0;
    chk("rst2_req", {31'd0, vram_req}, 32'd0);
    chk("rst2_underrun", {31'd0, underrun}, 32'd0);
    chk("rst2_pix", {28'd0, pix}, 32'd0);
    expect_req(12'd86, 16'h0000, 1, 'h000);
    run(16, 42, 52, 48, 8'h00, 4'h0, 4'h0);
    chk("first_trig_no_underrun", {31'd0, underrun}, 32'd0);

    @(negedge pclk); #1;
    chk("addr_q_drained", exp_addr_q.size(), 32'd0);
    chk("font_q_drained", exp_font_q.size(), 32'd0);
    chk("pix_q_drained", exp_pix_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
